// File: rtl/h_secded_pkg.sv
// Shared definitions for the Hamming(21,16) SECDED scrubber slice.
// Codeword layout (22 bits):
//   bit 0              overall parity over bits 21:1
//   bits 1,2,4,8,16    Hamming parity bits
//   bits 3,5-7,9-15,17-21  data bits 0..15, in ascending order
package h_secded_pkg;

  localparam int unsigned CW_W   = 22;
  localparam int unsigned DATA_W = 16;

  localparam logic [4:0] PAR_POS [5] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  localparam logic [4:0] DATA_POS [16] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } scrub_state_t;

  // Saturating 16-bit increment for the error counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/h_decoder_21_16.sv
// Hamming(21,16) SECDED decoder.
// Ports:
//   i_Code   : 22-bit codeword
//   o_Data   : 16-bit data, corrected when a single-bit error is present
//   o_ErrorC : single-bit (correctable) error detected
//   o_ErrorD : double / uncorrectable error detected
module h_decoder_21_16
  import h_secded_pkg::*;
(
  input  logic [CW_W-1:0]   i_Code,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_ErrorC,
  output logic              o_ErrorD
);

  logic [4:0]      w_Syn;
  logic            w_Par;
  logic [CW_W-1:0] w_Fix;

  // Syndrome is the XOR of the positions of all set bits in 21:1.
  always_comb begin
    w_Syn = '0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if (i_Code[i[4:0]]) w_Syn = w_Syn ^ i[4:0];
    end
  end

  assign w_Par = ^i_Code;

  // Odd overall parity means an odd number of flips; treat it as a single
  // error only when the syndrome points inside the codeword.
  assign o_ErrorC = w_Par && (w_Syn <= 5'd21);
  assign o_ErrorD = (!w_Par && (w_Syn != '0)) || (w_Par && (w_Syn > 5'd21));

  always_comb begin
    w_Fix = i_Code;
    if (o_ErrorC) w_Fix[w_Syn] = ~i_Code[w_Syn];
  end

  always_comb begin
    o_Data = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      o_Data[k[3:0]] = w_Fix[DATA_POS[k[3:0]]];
    end
  end

endmodule

// File: rtl/h_encoder_21_16.sv
// Hamming(21,16) SECDED encoder, same bit layout as h_decoder_21_16.
// Ports:
//   i_Data : 16-bit data
//   o_Code : 22-bit codeword, overall parity in bit 0 covering bits 21:1
module h_encoder_21_16
  import h_secded_pkg::*;
(
  input  logic [DATA_W-1:0] i_Data,
  output logic [CW_W-1:0]   o_Code
);

  logic [CW_W-1:0] w_Cw;
  logic            w_Bit;

  always_comb begin
    w_Cw  = '0;
    w_Bit = 1'b0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      w_Cw[DATA_POS[k[3:0]]] = i_Data[k[3:0]];
    end
    // Each parity bit covers the other positions sharing its index bit;
    // those are all data positions, which are already placed.
    for (int unsigned j = 0; j < 5; j++) begin
      w_Bit = 1'b0;
      for (int unsigned i = 1; i < CW_W; i++) begin
        if (((i[4:0] & PAR_POS[j[2:0]]) != '0) && (i[4:0] != PAR_POS[j[2:0]]))
          w_Bit = w_Bit ^ w_Cw[i[4:0]];
      end
      w_Cw[PAR_POS[j[2:0]]] = w_Bit;
    end
    w_Cw[0] = ^w_Cw[CW_W-1:1];
  end

  assign o_Code = w_Cw;

endmodule

// File: rtl/h_scrub_ctrl_21_16.sv
// Background scrubber for Hamming(21,16) SECDED codeword RAM.
// Walks addresses 0..DEPTH-1, corrects single-bit errors by write-back of a
// re-encoded word, and logs uncorrectable errors.
// Ports:
//   i_Clk, i_Rst_n      : clock, async active-low reset
//   i_Start, i_Abort    : start pulse (IDLE only), terminate pass
//   o_MemReq, i_MemGnt  : RAM request / grant handshake
//   o_MemWe, o_MemAddr, o_MemWData, i_MemRData : RAM access (rdata 1 cycle after grant)
//   o_Busy, o_Done      : non-IDLE indicator, end-of-pass pulse
//   o_CorrCnt, o_DetCnt : saturating corrected / uncorrectable counts
//   o_DetValid, o_FirstDetAddr : first uncorrectable error log for the pass
module h_scrub_ctrl_21_16
  import h_secded_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic              i_Abort,
  output logic              o_MemReq,
  input  logic              i_MemGnt,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [CW_W-1:0]   o_MemWData,
  input  logic [CW_W-1:0]   i_MemRData,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [15:0]       o_CorrCnt,
  output logic [15:0]       o_DetCnt,
  output logic              o_DetValid,
  output logic [ADDR_W-1:0] o_FirstDetAddr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_t        r_State;
  logic [ADDR_W-1:0]   r_Addr;
  logic [CW_W-1:0]     r_Code;
  logic [DATA_W-1:0]   r_Data;
  logic [15:0]         r_CorrCnt;
  logic [15:0]         r_DetCnt;
  logic                r_DetValid;
  logic [ADDR_W-1:0]   r_FirstDetAddr;

  logic [DATA_W-1:0]   w_DecData;
  logic                w_ErrC;
  logic                w_ErrD;
  logic [CW_W-1:0]     w_EncCode;

  h_decoder_21_16 u_dec (
    .i_Code   (r_Code),
    .o_Data   (w_DecData),
    .o_ErrorC (w_ErrC),
    .o_ErrorD (w_ErrD)
  );

  h_encoder_21_16 u_enc (
    .i_Data (r_Data),
    .o_Code (w_EncCode)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State        <= ST_IDLE;
      r_Addr         <= '0;
      r_Code         <= '0;
      r_Data         <= '0;
      r_CorrCnt      <= '0;
      r_DetCnt       <= '0;
      r_DetValid     <= 1'b0;
      r_FirstDetAddr <= '0;
    end else if ((r_State != ST_IDLE) && i_Abort) begin
      // A grant coinciding with abort has already transferred on the bus;
      // the FSM simply stops here with counters and logs untouched.
      r_State <= ST_IDLE;
    end else begin
      unique case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            r_CorrCnt      <= '0;
            r_DetCnt       <= '0;
            r_DetValid     <= 1'b0;
            r_FirstDetAddr <= '0;
            r_Addr         <= '0;
            r_State        <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (i_MemGnt) r_State <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          r_Code  <= i_MemRData;
          r_State <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_ErrC) begin
            r_CorrCnt <= sat_inc(r_CorrCnt);
            r_Data    <= w_DecData;
            r_State   <= ST_WR_REQ;
          end else if (w_ErrD) begin
            r_DetCnt <= sat_inc(r_DetCnt);
            if (!r_DetValid) begin
              r_DetValid     <= 1'b1;
              r_FirstDetAddr <= r_Addr;
            end
            r_State <= ST_NEXT;
          end else begin
            r_State <= ST_NEXT;
          end
        end
        ST_WR_REQ: begin
          if (i_MemGnt) r_State <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_Addr == LAST_ADDR) begin
            r_State <= ST_DONE;
          end else begin
            r_Addr  <= r_Addr + 1'b1;
            r_State <= ST_RD_REQ;
          end
        end
        ST_DONE: begin
          r_State <= ST_IDLE;
        end
        default: begin
          r_State <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_MemReq       = (r_State == ST_RD_REQ) || (r_State == ST_WR_REQ);
  assign o_MemWe        = (r_State == ST_WR_REQ);
  assign o_MemAddr      = r_Addr;
  assign o_MemWData     = w_EncCode;
  assign o_Busy         = (r_State != ST_IDLE);
  assign o_Done         = (r_State == ST_DONE);
  assign o_CorrCnt      = r_CorrCnt;
  assign o_DetCnt       = r_DetCnt;
  assign o_DetValid     = r_DetValid;
  assign o_FirstDetAddr = r_FirstDetAddr;

endmodule

// File: tb/tb_h_scrub_ctrl_21_16.sv
// Scoreboard bench for h_scrub_ctrl_21_16 with an 8-word RAM model.
module tb_h_scrub_ctrl_21_16;

  localparam int unsigned AW  = 4;
  localparam int unsigned DEP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          gnt = 1'b1;
  logic          req, we, busy, done, dv;
  logic [AW-1:0] addr, fa;
  logic [21:0]   wdata;
  logic [21:0]   rdata = '0;
  logic [15:0]   corr, det;

  always #5 clk = ~clk;

  h_scrub_ctrl_21_16 #(.ADDR_W(AW), .DEPTH(DEP)) u_dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Start        (start),
    .i_Abort        (abort),
    .o_MemReq       (req),
    .i_MemGnt       (gnt),
    .o_MemWe        (we),
    .o_MemAddr      (addr),
    .o_MemWData     (wdata),
    .i_MemRData     (rdata),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_CorrCnt      (corr),
    .o_DetCnt       (det),
    .o_DetValid     (dv),
    .o_FirstDetAddr (fa)
  );

  typedef struct {
    int unsigned addr;
    logic [21:0] data;
  } wr_t;

  typedef struct {
    int unsigned lat;
    logic [15:0] corr;
    logic [15:0] det;
    logic        dv;
    int unsigned fa;
  } done_t;

  wr_t   exp_wr_q[$];
  done_t exp_done_q[$];

  int checks   = 0;
  int failures = 0;

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  logic [21:0] mem [8];
  logic [21:0] img [8];
  logic        load = 1'b0;

  logic [15:0] tbl [8] = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0001,
                           16'h8000, 16'h5A5A, 16'h00FF, 16'hC3C3};

  int  stall_left = 0;
  bit  stall_on   = 1'b0;
  bit  hold_wr    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data appears the cycle after a granted read.
  always @(posedge clk) begin
    if (load) begin
      mem <= img;
    end else if (req && gnt) begin
      if (we) mem[addr[2:0]] <= wdata;
      else    rdata <= mem[addr[2:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent encoder: data fills non-power-of-two positions in order.
  function automatic logic [21:0] enc_model(input logic [15:0] d);
    logic [21:0] c;
    int          k;
    logic        x;
    int          pp;
    c = '0;
    k = 0;
    for (int p = 1; p < 22; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p[4:0]] = d[k[3:0]];
        k++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      x  = 1'b0;
      pp = 1 << b;
      for (int p = 1; p < 22; p++) begin
        if ((((p >> b) & 1) == 1) && (p != pp)) x = x ^ c[p[4:0]];
      end
      c[pp[4:0]] = x;
    end
    c[0] = ^c[21:1];
    return c;
  endfunction

  // Grant driver: optional 10-cycle stall on the read of address 2,
  // optional indefinite withholding of writes.
  always begin
    @(posedge clk);
    #2;
    if ((stall_left > 0) && (stall_on || (req && !we && addr == 4'd2))) begin
      if (stall_on) begin
        chk("stall_req_stable", {29'd0, req, we, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("stall_addr_stable", {28'd0, addr}, 32'd2);
      end
      stall_on = 1'b1;
      gnt      = 1'b0;
      stall_left--;
    end else begin
      stall_on = 1'b0;
      gnt      = !(hold_wr && req && we);
    end
  end

  // Monitor: pops expectations whenever the DUT writes or completes.
  always @(negedge clk) begin : monitor
    wr_t   e;
    done_t d;
    if (rst_n && req && gnt && we) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected actual_addr=%0d actual_data=%h required=no_write", addr, wdata);
      end else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", {28'd0, addr}, e.addr);
        chk("wr_data", {10'd0, wdata}, {10'd0, e.data});
      end
    end
    if (rst_n && done) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        d = exp_done_q.pop_front();
        chk("done_latency", cyc - start_cyc + 1, d.lat);
        chk("done_corr", {16'd0, corr}, {16'd0, d.corr});
        chk("done_det", {16'd0, det}, {16'd0, d.det});
        chk("done_detvalid", {31'd0, dv}, {31'd0, d.dv});
        chk("done_firstaddr", {28'd0, fa}, d.fa);
      end
    end
  end

  task automatic push_done(input int unsigned lat, input logic [15:0] c, input logic [15:0] dt,
                           input logic v, input int unsigned a);
    done_t d;
    d.lat = lat; d.corr = c; d.det = dt; d.dv = v; d.fa = a;
    exp_done_q.push_back(d);
  endtask

  task automatic push_wr(input int unsigned a, input logic [21:0] dat);
    wr_t e;
    e.addr = a; e.data = dat;
    exp_wr_q.push_back(e);
  endtask

  task automatic load_mem();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic start_pass();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_wr_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=drained", name);
      exp_done_q.delete();
      exp_wr_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_req"},   {30'd0, req, we}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_addr"},  {28'd0, addr}, 32'd0);
    chk({tag, "_wdata"}, {10'd0, wdata}, 32'd0);
    chk({tag, "_cnts"},  {corr, det}, 32'd0);
    chk({tag, "_log"},   {27'd0, dv, fa}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) img[i] = enc_model(tbl[i]);
    img[3] = 22'h00000F;  // hand-encoded 16'h0001
    load_mem();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Clean pass: 4 cycles per word, done on cycle 33, no writes.
    push_done(33, 16'd0, 16'd0, 1'b0, 0);
    start_pass();
    wait_drain("clean");

    // Single-bit error in bit 7 at address 3.
    img[3] = 22'h00000F ^ 22'h000080;
    load_mem();
    push_wr(3, 22'h00000F);
    push_done(34, 16'd1, 16'd0, 1'b0, 0);
    start_pass();
    wait_drain("single");
    chk("single_mem3_fixed", {10'd0, mem[3]}, 32'h0000000F);
    push_done(33, 16'd0, 16'd0, 1'b0, 0);
    start_pass();
    wait_drain("reread");

    // Double errors at addresses 5 and 6.
    img[3] = 22'h00000F;
    img[5] = enc_model(tbl[5]) ^ 22'h000220;
    img[6] = enc_model(tbl[6]) ^ 22'h001008;
    load_mem();
    push_done(33, 16'd0, 16'd2, 1'b1, 5);
    start_pass();
    wait_drain("double");

    // 10-cycle grant stall on the read of address 2.
    img[5] = enc_model(tbl[5]);
    img[6] = enc_model(tbl[6]);
    load_mem();
    stall_left = 10;
    push_done(43, 16'd0, 16'd0, 1'b0, 0);
    start_pass();
    wait_drain("stall");

    // Abort in CHECK of address 4, after one correction and one detection.
    img[1] = enc_model(tbl[1]) ^ 22'h000004;
    img[2] = enc_model(tbl[2]) ^ 22'h000030;
    load_mem();
    push_wr(1, enc_model(tbl[1]));
    start_pass();
    n = 0;
    while (!(req && !we && addr == 4'd4) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reach_addr4", n < 200, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_check_addr", {28'd0, addr}, 32'd4);
    chk("abort_check_noreq", {31'd0, req}, 32'd0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_corr", {16'd0, corr}, 32'd1);
    chk("abort_det", {16'd0, det}, 32'd1);
    chk("abort_log", {27'd0, dv, fa}, {27'd0, 1'b1, 4'd2});
    repeat (6) @(posedge clk);
    chk("abort_pending_wr", exp_wr_q.size(), 0);
    img[1] = enc_model(tbl[1]);
    img[2] = enc_model(tbl[2]);
    load_mem();
    push_done(33, 16'd0, 16'd0, 1'b0, 0);
    start_pass();
    chk("restart_addr", {28'd0, addr}, 32'd0);
    chk("restart_req", {30'd0, req, we}, 32'd2);
    chk("restart_cnts", {corr, det}, 32'd0);
    chk("restart_log", {27'd0, dv, fa}, 32'd0);
    wait_drain("restart");

    // Reset while a correction write is waiting for grant.
    img[1] = enc_model(tbl[1]) ^ 22'h000004;
    load_mem();
    hold_wr = 1'b1;
    start_pass();
    n = 0;
    while (!(req && we) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reach_write", n < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_write_dropped", {10'd0, mem[1]}, {10'd0, img[1]});
    @(negedge clk) rst_n = 1'b1;
    hold_wr = 1'b0;
    img[1] = enc_model(tbl[1]);
    load_mem();
    push_done(33, 16'd0, 16'd0, 1'b0, 0);
    start_pass();
    wait_drain("post_reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/h_scrub_ctrl_21_16.md
# h_scrub_ctrl_21_16

Background memory scrubber for Hamming(21,16) SECDED-protected storage. It walks every address of a codeword RAM and decodes each word through an instance of `h_decoder_21_16`. Single-bit errors are corrected by writing back a re-encoded word; double errors are logged. It shares the RAM port with the functional path through a request/grant handshake and sits beside the RAM's arbiter.

## Interface
- `ADDR_W`, default 8: address width.
- `DEPTH`, default 256: number of words scrubbed per pass, at addresses 0..DEPTH-1. Must satisfy DEPTH ≤ 2**ADDR_W.
- `i_Clk` in 1: clock; all state on rising edge.
- `i_Rst_n` in 1: reset, asynchronous, active-low.
- `i_Start` in 1: single-cycle pulse that starts a pass. Accepted only in IDLE.
- `i_Abort` in 1: terminates the pass in progress.
- `o_MemReq` out 1: RAM access request. Held with stable address, write enable and write data until granted.
- `i_MemGnt` in 1: grant. An access transfers in a cycle where `o_MemReq` and `i_MemGnt` are both high.
- `o_MemWe` out 1: 1 = write, 0 = read.
- `o_MemAddr` out ADDR_W: access address.
- `o_MemWData` out 22: write codeword.
- `i_MemRData` in 22: read codeword, valid the cycle after a granted read.
- `o_Busy` out 1: high in every non-IDLE state.
- `o_Done` out 1: one-cycle pulse when a pass completes.
- `o_CorrCnt` out 16: corrected-error count, saturating.
- `o_DetCnt` out 16: uncorrectable-error count, saturating.
- `o_DetValid` out 1: at least one uncorrectable error seen this pass.
- `o_FirstDetAddr` out ADDR_W: address of the first uncorrectable error in the pass.

## Operation
- **Reset:**
  - FSM enters IDLE.
  - All outputs reset to 0: `o_MemReq`, `o_MemWe`, `o_MemAddr`, `o_MemWData`, `o_Busy`, `o_Done`, both counters, `o_DetValid`, `o_FirstDetAddr`.
- **FSM states:** IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE.
- **IDLE:**
  - On `i_Start`: clear the counters, `o_DetValid` and `o_FirstDetAddr`; set addr=0; go to RD_REQ.
  - `i_Start` is ignored in every other state.
- **RD_REQ:**
  - Drive `o_MemReq`=1, `o_MemWe`=0, `o_MemAddr`=addr.
  - On grant, go to RD_WAIT.
- **RD_WAIT:** capture `i_MemRData` into the codeword register; go to CHECK.
- **CHECK:** the decoder input is the codeword register. Branch on the decoder flags:
  - ErrorC: increment `o_CorrCnt`; latch the decoded data; go to WR_REQ.
  - ErrorD: increment `o_DetCnt`. If `o_DetValid`=0, set `o_DetValid`=1 and `o_FirstDetAddr`=addr. Go to NEXT with no write.
  - Neither flag: go to NEXT.
- **WR_REQ:**
  - Drive `o_MemReq`=1, `o_MemWe`=1, `o_MemAddr`=addr, `o_MemWData`=encode(latched data).
  - On grant, go to NEXT.
- **NEXT:** if addr==DEPTH-1, go to DONE; otherwise addr+1 and go to RD_REQ. addr never wraps within a pass.
- **DONE:** `o_Done`=1 for one cycle, then IDLE.
- **Counters:** saturate at 16'hFFFF; they do not wrap. Values hold after a pass until the next accepted `i_Start`.
- **Abort:** `i_Abort` in any non-IDLE state moves the FSM to IDLE at the next edge with no `o_Done`.
  - If a request is granted in the same cycle as `i_Abort`, that access is committed.
  - Counters and logs keep their values.
  - If `i_Start` and `i_Abort` arrive together in IDLE, the start is accepted and the abort is ignored.
- **Outside RD_REQ/WR_REQ:** `o_MemReq`=0 and `o_MemWe`=0.

## Timing
- Grant is combinationally sampled. The request drops the cycle after the granted edge.
- Read data latency is exactly 1 cycle after the granted cycle.
- Cycles per clean word with immediate grant: 4 (RD_REQ, RD_WAIT, CHECK, NEXT).
- Cycles per corrected word with immediate grant: 5.
- Clean full pass with immediate grants: `o_Done` asserted 4·DEPTH+1 cycles after the `i_Start` edge.
- Grant stall: each cycle of grant withheld adds one cycle; request, address and data stay stable throughout.
- Reset asserted mid-pass clears everything asynchronously. A half-issued write is dropped.

## Structure
- Shared package `h_secded_pkg`:
  - Codeword width 22 and data width 16.
  - Parity positions 0, 1, 2, 4, 8, 16; data positions 3, 5–7, 9–15, 17–21.
  - FSM state enum `scrub_state_t`.
- New combinational sub-module `h_encoder_21_16`: 16-bit data in, 22-bit codeword out. It uses the same bit layout as the decoder, with overall parity in bit 0 covering bits 21:1.
- Instances: one `h_decoder_21_16` and one `h_encoder_21_16`.

## Test plan
- **Clean pass:** DEPTH=8, all-valid codewords, grant tied high.
  - `o_Done` pulses 33 cycles after start.
  - CorrCnt=0, DetCnt=0, no write requests.
- **Single-bit error:** flip bit 7 of the codeword at addr 3.
  - Exactly one write, to addr 3, with the original correct codeword.
  - CorrCnt=1; re-reading addr 3 decodes with no flags.
- **Double errors:** bits 5 and 9 flipped at addr 5; bits 3 and 12 flipped at addr 6.
  - DetCnt=2, `o_DetValid`=1, `o_FirstDetAddr`=5.
  - No writes.
- **Grant stall:** hold `i_MemGnt` low for 10 cycles during RD_REQ at addr 2.
  - `o_MemReq`, `o_MemAddr`=2 and `o_MemWe`=0 stay stable.
  - Pass completes 10 cycles late.
- **Abort:** pulse `i_Abort` at addr 4 in CHECK.
  - `o_Busy` drops next cycle, no `o_Done`, counters held.
  - A later `i_Start` clears the counters and restarts from addr 0.
- **Mid-pass reset:** deassert `i_Rst_n` mid-pass.
  - All outputs are 0 immediately; `i_Start` is accepted after reset release.
